// File: rtl/wb_scoreboard.sv
// Writeback stage: merges the ALU and memory result streams into one registered
// register-file write port, and keeps a per-register pending scoreboard that
// decode uses to stall on RAW/WAW hazards.
module wb_scoreboard #(
   parameter int MEM_FIFO_DEPTH = 2,
   parameter int XLEN           = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            issue_valid,
   input  logic [4:0]      issue_rd,
   input  logic            issue_wr,
   input  logic [4:0]      issue_rs1,
   input  logic [4:0]      issue_rs2,
   input  logic            issue_use_rs1,
   input  logic            issue_use_rs2,
   output logic            issue_stall,
   input  logic            alu_valid,
   input  logic [4:0]      alu_rd,
   input  logic [XLEN-1:0] alu_data,
   input  logic            mem_valid,
   input  logic [4:0]      mem_rd,
   input  logic [XLEN-1:0] mem_data,
   output logic            mem_ready,
   output logic [4:0]      rf_rd,
   output logic            rf_we,
   output logic [XLEN-1:0] rf_wdata,
   output logic [31:0]     pending,
   output logic            wb_err
);

   localparam int AW = (MEM_FIFO_DEPTH > 2) ? $clog2(MEM_FIFO_DEPTH) : 1;
   localparam logic [AW:0] DEPTH_L = (AW+1)'(MEM_FIFO_DEPTH);

   // Memory-result skid FIFO storage and control
   logic [4:0]      fifo_rd_mem   [MEM_FIFO_DEPTH];
   logic [XLEN-1:0] fifo_data_mem [MEM_FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
   logic [AW:0]     count_reg, count_next;
   logic            mem_ready_reg;

   // Output stage registers
   logic            rf_we_reg;
   logic [4:0]      rf_rd_reg;
   logic [XLEN-1:0] rf_wdata_reg;

   // Scoreboard
   logic [31:0]     pending_reg, pending_next;
   logic [31:0]     clear_mask, set_mask, eff_pending;
   logic            wb_err_reg;

   logic            mem_accept, fifo_empty, push, pop;
   logic            sel_valid, sel_bypass;
   logic [4:0]      sel_rd;
   logic [XLEN-1:0] sel_data;
   logic            issue_accept;
   logic            stall_rs1, stall_rs2, stall_rd;

   assign mem_accept = mem_valid && mem_ready_reg;
   assign fifo_empty = (count_reg == '0);

   // Output-stage source selection: ALU first, then queued memory, then bypass
   always_comb begin
      sel_valid  = 1'b0;
      sel_bypass = 1'b0;
      pop        = 1'b0;
      sel_rd     = alu_rd;
      sel_data   = alu_data;
      if (alu_valid) begin
         sel_valid = 1'b1;
      end else if (!fifo_empty) begin
         sel_valid = 1'b1;
         pop       = 1'b1;
         sel_rd    = fifo_rd_mem[rd_ptr_reg];
         sel_data  = fifo_data_mem[rd_ptr_reg];
      end else if (mem_accept) begin
         sel_valid  = 1'b1;
         sel_bypass = 1'b1;
         sel_rd     = mem_rd;
         sel_data   = mem_data;
      end
   end

   // An accepted memory result that did not go straight out is queued
   assign push = mem_accept && !sel_bypass;

   // Next FIFO occupancy
   always_comb begin
      count_next = count_reg;
      case ({push, pop})
         2'b10:   count_next = count_reg + (AW+1)'(1);
         2'b01:   count_next = count_reg - (AW+1)'(1);
         default: count_next = count_reg;
      endcase
   end

   // FIFO storage writes (no reset needed on the data array)
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_rd_mem[wr_ptr_reg]   <= mem_rd;
         fifo_data_mem[wr_ptr_reg] <= mem_data;
      end
   end

   // FIFO pointers, occupancy and the registered ready
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
         mem_ready_reg <= 1'b1;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
         count_reg     <= count_next;
         mem_ready_reg <= (count_next < DEPTH_L);
      end
   end

   // Registered write port; address/data hold when nothing (or x0) is written
   always_ff @(posedge clk) begin
      if (rst) begin
         rf_we_reg    <= 1'b0;
         rf_rd_reg    <= '0;
         rf_wdata_reg <= '0;
      end else begin
         rf_we_reg <= sel_valid && (sel_rd != 5'd0);
         if (sel_valid && (sel_rd != 5'd0)) begin
            rf_rd_reg    <= sel_rd;
            rf_wdata_reg <= sel_data;
         end
      end
   end

   assign issue_accept = issue_valid && !issue_stall && issue_wr;

   // Per-register clear (retiring write) and set (accepted issue) masks
   generate
      for (genvar gi = 0; gi < 32; gi++) begin : g_mask
         assign clear_mask[gi] = rf_we_reg && (rf_rd_reg == 5'(gi));
         assign set_mask[gi]   = (gi != 0) && issue_accept && (issue_rd == 5'(gi));
      end
   endgenerate

   // A write retiring this cycle is already visible to decode reads
   assign eff_pending = pending_reg & ~clear_mask;

   assign stall_rs1   = issue_use_rs1 && (issue_rs1 != 5'd0) && eff_pending[issue_rs1];
   assign stall_rs2   = issue_use_rs2 && (issue_rs2 != 5'd0) && eff_pending[issue_rs2];
   assign stall_rd    = issue_wr && (issue_rd != 5'd0) && eff_pending[issue_rd];
   assign issue_stall = issue_valid && (stall_rs1 || stall_rs2 || stall_rd);

   // Set is applied after clear so a same-cycle reissue keeps the bit
   assign pending_next = ((pending_reg & ~clear_mask) | set_mask) & ~32'd1;

   // Scoreboard and sticky error flag
   always_ff @(posedge clk) begin
      if (rst) begin
         pending_reg <= '0;
         wb_err_reg  <= 1'b0;
      end else begin
         pending_reg <= pending_next;
         if (rf_we_reg && (rf_rd_reg != 5'd0) && !pending_reg[rf_rd_reg])
            wb_err_reg <= 1'b1;
      end
   end

   assign mem_ready = mem_ready_reg;
   assign rf_we     = rf_we_reg;
   assign rf_rd     = rf_rd_reg;
   assign rf_wdata  = rf_wdata_reg;
   assign pending   = pending_reg;
   assign wb_err    = wb_err_reg;

endmodule

// File: tb/tb_wb_scoreboard.sv
// Directed self-checking bench for wb_scoreboard (DEPTH=2, XLEN=32).
module tb_wb_scoreboard;

   logic        clk = 1'b0;
   logic        rst;
   logic        issue_valid, issue_wr, issue_use_rs1, issue_use_rs2;
   logic [4:0]  issue_rd, issue_rs1, issue_rs2;
   logic        issue_stall;
   logic        alu_valid, mem_valid, mem_ready;
   logic [4:0]  alu_rd, mem_rd, rf_rd;
   logic [31:0] alu_data, mem_data, rf_wdata, pending;
   logic        rf_we, wb_err;

   int n_cmp = 0;
   int n_bad = 0;

   wb_scoreboard #(.MEM_FIFO_DEPTH(2), .XLEN(32)) dut (
      .clk(clk), .rst(rst),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_wr(issue_wr),
      .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
      .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2),
      .issue_stall(issue_stall),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
      .mem_ready(mem_ready),
      .rf_rd(rf_rd), .rf_we(rf_we), .rf_wdata(rf_wdata),
      .pending(pending), .wb_err(wb_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end else begin
         $display("ok   %s: 0x%08h", tag, obs);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      issue_valid = 0; issue_wr = 0; issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
      issue_use_rs1 = 0; issue_use_rs2 = 0;
      alu_valid = 0; alu_rd = 0; alu_data = 0;
      mem_valid = 0; mem_rd = 0; mem_data = 0;
   endtask

   task automatic issue_write(input logic [4:0] rd);
      issue_valid = 1; issue_wr = 1; issue_rd = rd;
      tick();
      issue_valid = 0; issue_wr = 0; issue_rd = 0;
   endtask

   int exp_ready [9] = '{1, 1, 0, 0, 0, 1, 1, 1, 1};
   int exp_we    [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
   int exp_rdv   [9] = '{0, 0, 0, 0, 8, 9, 10, 11, 0};

   initial begin
      idle();
      rst = 1;
      tick(); tick();
      rst = 0;
      // Reset state
      chk("rst_rf_we", 32'(rf_we), 32'd0);
      chk("rst_rf_rd", 32'(rf_rd), 32'd0);
      chk("rst_rf_wdata", rf_wdata, 32'd0);
      chk("rst_pending", pending, 32'd0);
      chk("rst_wb_err", 32'(wb_err), 32'd0);
      chk("rst_mem_ready", 32'(mem_ready), 32'd1);

      // ALU write to x5
      issue_valid = 1; issue_wr = 1; issue_rd = 5; #1;
      chk("issue5_stall", 32'(issue_stall), 32'd0);
      tick();
      issue_valid = 0; issue_wr = 0; issue_rd = 0;
      chk("pend5_set", pending, 32'h0000_0020);
      alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
      tick();
      alu_valid = 0;
      chk("alu_we", 32'(rf_we), 32'd1);
      chk("alu_rd", 32'(rf_rd), 32'd5);
      chk("alu_wdata", rf_wdata, 32'hDEADBEEF);
      tick();
      chk("alu_we_off", 32'(rf_we), 32'd0);
      chk("pend5_clr", pending, 32'd0);
      chk("alu_rd_hold", 32'(rf_rd), 32'd5);
      chk("alu_err", 32'(wb_err), 32'd0);

      // RAW / WAW stall on x7
      issue_write(7);
      issue_valid = 1; issue_use_rs1 = 1; issue_rs1 = 7; #1;
      chk("raw7_stall", 32'(issue_stall), 32'd1);
      issue_rs1 = 0; #1;
      chk("raw0_nostall", 32'(issue_stall), 32'd0);
      issue_use_rs1 = 0; issue_wr = 1; issue_rd = 7; #1;
      chk("waw7_stall", 32'(issue_stall), 32'd1);
      issue_wr = 0; issue_rd = 0; issue_use_rs1 = 1; issue_rs1 = 7;
      alu_valid = 1; alu_rd = 7; alu_data = 32'h77;
      tick();
      alu_valid = 0;
      chk("raw7_we", 32'(rf_we), 32'd1);
      chk("raw7_release", 32'(issue_stall), 32'd0);
      idle();
      tick();
      chk("pend7_clr", pending, 32'd0);

      // ALU / memory contention
      issue_write(3);
      issue_write(4);
      alu_valid = 1; alu_rd = 3; alu_data = 32'h11;
      mem_valid = 1; mem_rd = 4; mem_data = 32'h22; #1;
      chk("cont_ready", 32'(mem_ready), 32'd1);
      tick();
      idle();
      chk("cont_x3", {rf_wdata[23:0], 3'd0, rf_rd}, {24'h11, 8'd3});
      chk("cont_we1", 32'(rf_we), 32'd1);
      tick();
      chk("cont_x4", {rf_wdata[23:0], 3'd0, rf_rd}, {24'h22, 8'd4});
      chk("cont_we2", 32'(rf_we), 32'd1);
      tick();
      chk("cont_idle", 32'(rf_we), 32'd0);
      chk("cont_pend", pending, 32'd0);

      // Backpressure: ALU (to x0) busy 4 cycles while memory offers x8..x11
      issue_write(8); issue_write(9); issue_write(10); issue_write(11);
      begin
         int mi = 0;
         for (int c = 0; c < 9; c++) begin
            logic acc;
            alu_valid = (c < 4); alu_rd = 0; alu_data = 32'(c);
            mem_valid = (mi < 4); mem_rd = 5'(8 + mi); mem_data = 32'((8 + mi) * 16);
            #1;
            chk($sformatf("bp_ready_c%0d", c), 32'(mem_ready), 32'(exp_ready[c]));
            acc = mem_valid && mem_ready;
            tick();
            if (acc) mi++;
            chk($sformatf("bp_we_c%0d", c), 32'(rf_we), 32'(exp_we[c]));
            if (exp_we[c] != 0) begin
               chk($sformatf("bp_rd_c%0d", c), 32'(rf_rd), 32'(exp_rdv[c]));
               chk($sformatf("bp_data_c%0d", c), rf_wdata, 32'(exp_rdv[c] * 16));
            end
         end
         chk("bp_all_accepted", 32'(mi), 32'd4);
      end
      idle();
      chk("bp_pend", pending, 32'd0);
      chk("bp_err", 32'(wb_err), 32'd0);

      // x0 write is dropped, x9 write without pending raises sticky error
      alu_valid = 1; alu_rd = 0; alu_data = 32'h99;
      tick();
      chk("x0_we", 32'(rf_we), 32'd0);
      chk("x0_rd_hold", 32'(rf_rd), 32'd11);
      chk("x0_data_hold", rf_wdata, 32'hB0);
      alu_rd = 9; alu_data = 32'h1234;
      tick();
      alu_valid = 0;
      chk("err_we", 32'(rf_we), 32'd1);
      chk("err_rd", 32'(rf_rd), 32'd9);
      tick();
      chk("err_set", 32'(wb_err), 32'd1);
      tick(); tick();
      chk("err_sticky", 32'(wb_err), 32'd1);

      // Set/clear collision on x6
      issue_write(6);
      alu_valid = 1; alu_rd = 6; alu_data = 32'h66;
      tick();
      alu_valid = 0;
      issue_valid = 1; issue_wr = 1; issue_rd = 6; #1;
      chk("coll_nostall", 32'(issue_stall), 32'd0);
      tick();
      idle();
      chk("coll_pend6", pending, 32'h0000_0040);

      // Fill the FIFO, then reset mid-operation
      alu_valid = 1; alu_rd = 0;
      mem_valid = 1; mem_rd = 12; mem_data = 32'hC0;
      tick();
      mem_rd = 13; mem_data = 32'hD0;
      tick();
      chk("full_ready", 32'(mem_ready), 32'd0);
      idle();
      rst = 1;
      tick();
      rst = 0;
      chk("mrst_we", 32'(rf_we), 32'd0);
      chk("mrst_pend", pending, 32'd0);
      chk("mrst_ready", 32'(mem_ready), 32'd1);
      chk("mrst_err", 32'(wb_err), 32'd0);
      tick();
      chk("mrst_flushed", 32'(rf_we), 32'd0);
      tick();
      chk("mrst_flushed2", 32'(rf_we), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/wb_scoreboard.md
Name: wb_scoreboard

Overview:
- Writeback stage of the pipelined core; sits directly upstream of the register file's single write port.
- Merges results from the single-cycle ALU path and the variable-latency memory/load path into one registered write stream (rf_rd/rf_we/rf_wdata).
- Keeps a per-register pending scoreboard so decode stalls on RAW and WAW hazards against results still in flight.

Parameters:
- MEM_FIFO_DEPTH, 2, entries in the memory-result skid FIFO (power of two, ≥2).
- XLEN, 32, data width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- issue_valid  in  1  decode presents an instruction this cycle.
- issue_rd  in  5  destination register of issuing instruction.
- issue_wr  in  1  issuing instruction writes rd.
- issue_rs1  in  5  source 1.
- issue_rs2  in  5  source 2.
- issue_use_rs1  in  1  rs1 is read.
- issue_use_rs2  in  1  rs2 is read.
- issue_stall  out  1  combinational; decode must hold the instruction.
- alu_valid  in  1  ALU result valid; no backpressure, always accepted.
- alu_rd  in  5  ALU destination.
- alu_data  in  XLEN  ALU result.
- mem_valid  in  1  memory result valid.
- mem_rd  in  5  memory destination.
- mem_data  in  XLEN  memory result.
- mem_ready  out  1  registered; memory result accepted when mem_valid && mem_ready.
- rf_rd  out  5  register-file write address.
- rf_we  out  1  register-file write enable.
- rf_wdata  out  XLEN  register-file write data.
- pending  out  32  scoreboard bit vector; bit 0 always 0.
- wb_err  out  1  sticky: a write retired to a register that was not pending.

Behaviour:
- Reset (rst=1 at a rising edge):
  - rf_we=0, rf_rd=0, rf_wdata=0, pending=0, wb_err=0.
  - FIFO emptied; mem_ready=1 on the following cycle.
  - Reset mid-operation discards all in-flight results.
- Output stage: registered, selected once per cycle in strict priority:
  - (1) alu_valid → ALU result.
  - (2) FIFO non-empty → FIFO head, popped.
  - (3) mem_valid && mem_ready with FIFO empty → memory result, direct bypass.
  - The selected result appears on rf_* at the next edge with rf_we=1; otherwise rf_we=0 and rf_rd/rf_wdata hold their last values.
- Latency:
  - ALU: 1 cycle.
  - Memory: 1 cycle when uncontended; otherwise queued, in order.
- FIFO:
  - Push when a memory result is accepted but not selected by the output stage.
  - mem_ready is registered: 1 iff FIFO occupancy at the next edge < MEM_FIFO_DEPTH.
  - No push while full. Push and pop in the same cycle leave occupancy unchanged.
- x0:
  - A result with rd=0 is consumed (popped/accepted) but produces rf_we=0.
  - x0 never becomes pending and never stalls.
- Scoreboard:
  - clear_mask = bit rf_rd when rf_we=1. The register file writes on the falling edge inside that cycle, so decode reads in that cycle see the new value.
  - eff_pending = pending & ~clear_mask.
  - issue_stall = issue_valid && ((issue_use_rs1 && eff_pending[rs1]) || (issue_use_rs2 && eff_pending[rs2]) || (issue_wr && eff_pending[rd])). Register 0 is excluded in all three terms.
  - Set: issue_valid && !issue_stall && issue_wr && rd≠0 sets pending[rd] at the edge.
  - Clear: the edge ending an rf_we=1 cycle clears pending[rf_rd].
  - If set and clear target the same register in the same cycle, set wins (pending stays 1).
- wb_err: set when rf_we=1 with pending[rf_rd]=0 and rf_rd≠0; stays set until rst.
- WAW stall guarantees at most one outstanding write per register; a single bit per register suffices.

Test Plan:
- Reset then ALU write: issue rd=5, then alu_valid rd=5 data=0xDEADBEEF → rf_we=1, rf_rd=5, rf_wdata=0xDEADBEEF one cycle later; pending[5] 1→0; wb_err=0.
- RAW stall: pending[7]=1, issue rs1=7 use_rs1=1 → issue_stall=1. In the cycle rf_we=1, rf_rd=7 → issue_stall=0. Same case with rs1=0 → never stalls.
- Contention: alu_valid (rd=3, 0x11) and mem_valid (rd=4, 0x22) in the same cycle →
  - rf writes x3=0x11 then x4=0x22 on consecutive cycles.
  - FIFO occupancy goes 1 then 0.
- Backpressure: alu_valid held 4 cycles while mem_valid offers rd=8..11 →
  - mem_ready drops to 0 after 2 accepts (DEPTH=2).
  - No data lost; all memory writes retire in order once ALU idles.
- x0 and error: alu_valid rd=0 → rf_we stays 0. alu_valid rd=9 with pending[9]=0 → rf_we=1 and wb_err=1, sticky until rst.
- Set/clear collision and mid-op reset:
  - Retire x6 while a new issue with rd=6 is accepted in the same cycle → pending[6] remains 1.
  - Assert rst with FIFO full → pending=0, rf_we=0, mem_ready=1 after reset.
